// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the memory stage: status codes, icodes, register id, FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package y86_pkg;

    localparam logic [3:0] AOK = 4'b1000;
    localparam logic [3:0] HLT = 4'b0100;
    localparam logic [3:0] ADR = 4'b0010;
    localparam logic [3:0] INS = 4'b0001;

    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } mem_fsm_e;

    function automatic logic is_mem_rd(input logic [3:0] icode);
        return (icode == MRMOVQ) || (icode == RET) || (icode == POPQ);
    endfunction

    function automatic logic is_mem_wr(input logic [3:0] icode);
        return (icode == RMMOVQ) || (icode == CALL) || (icode == PUSHQ);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// 64-bit word data memory: synchronous write, combinational read.
// Latency: write lands at the clock edge, read is same-cycle.
// Backpressure: none; always accepts a write when i_we is high.
// Ports: clk; i_we/i_widx/i_wdata write port; i_ridx/o_rdata read port.
// Contents are intentionally not reset.
module dmem_array #(
    parameter  int MEM_WORDS = 256,
    localparam int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_widx,
    input  logic [63:0]   i_wdata,
    input  logic [AW-1:0] i_ridx,
    output logic [63:0]   o_rdata
);

    logic [63:0] r_mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/mem_stage_mc.sv
// Y86-64 memory stage with wait-state data memory and M->W pipeline register.
// Latency: 1 + WAIT_CYCLES cycles per enabled access; W register loads one edge after completion.
// Backpressure: mem_busy asks the hazard unit to stall F/D/E/M; W_stall holds W (and parks in HOLD).
// Ports: clk/rst; M_* stage inputs; W_stall/W_bubble; m_stat/m_valM/mem_busy combinational; W_* registered.
// Optional macro MEM_ALIGN_CHECK_EN: non 8-byte-aligned memory addresses report ADR and do not access.
module mem_stage_mc
    import y86_pkg::*;
#(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic        W_stall,
    input  logic        W_bubble,
    output logic [3:0]  m_stat,
    output logic [63:0] m_valM,
    output logic        mem_busy,
    output logic [3:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM
);

    localparam int AW = $clog2(MEM_WORDS);
    // Keep the counter at least one bit wide so the single-cycle build still elaborates.
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WC = CW'(WAIT_CYCLES);

    mem_fsm_e      r_state;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_hold;

    logic [3:0]  r_w_stat;
    logic [3:0]  r_w_icode;
    logic [63:0] r_w_vale;
    logic [63:0] r_w_valm;
    logic [3:0]  r_w_dste;
    logic [3:0]  r_w_dstm;

    logic          w_is_rd;
    logic          w_is_wr;
    logic          w_is_mem;
    logic [63:0]   w_addr;
    logic          w_addr_ok;
    logic          w_acc_en;
    logic [AW-1:0] w_widx;
    logic [63:0]   w_rdata;
    logic          w_we;
    logic          w_busy;
    logic          w_done;
    logic [63:0]   w_valm;

    assign w_is_rd  = is_mem_rd(M_icode);
    assign w_is_wr  = is_mem_wr(M_icode);
    assign w_is_mem = w_is_rd || w_is_wr;
    // ret and popq read from the old stack pointer carried in valA.
    assign w_addr   = ((M_icode == RET) || (M_icode == POPQ)) ? M_valA : M_valE;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_addr_ok = (w_addr[63:AW+3] == '0) && (w_addr[2:0] == 3'b000);
`else
    assign w_addr_ok = (w_addr[63:AW+3] == '0);
`endif

    assign w_widx   = w_addr[AW+2:3];
    // The address check overrides any incoming status, including non-AOK.
    assign m_stat   = (w_is_mem && !w_addr_ok) ? ADR : M_stat;
    // Nothing touches memory behind an instruction that is already faulting in W.
    assign w_acc_en = w_is_mem && (M_stat == AOK) && w_addr_ok && (r_w_stat == AOK);

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        w_valm = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_acc_en) begin
                    if (WAIT_CYCLES == 0) begin
                        w_done = 1'b1;
                    end else begin
                        w_busy = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt < WC) begin
                    w_busy = 1'b1;
                end else begin
                    w_done = 1'b1;
                end
            end
            ST_HOLD: w_valm = r_hold;
            default: w_valm = '0;
        endcase
        if (w_done && w_is_rd) begin
            w_valm = w_rdata;
        end
    end

    // Writes only on the completion cycle; a reset on that edge aborts it.
    assign w_we     = w_done && w_is_wr && !rst;
    assign m_valM   = w_valm;
    assign mem_busy = w_busy;

    dmem_array #(
        .MEM_WORDS(MEM_WORDS)
    ) u_dmem (
        .clk    (clk),
        .i_we   (w_we),
        .i_widx (w_widx),
        .i_wdata(M_valA),
        .i_ridx (w_widx),
        .o_rdata(w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if ((WAIT_CYCLES != 0) && w_acc_en) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (r_cnt < WC) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        // Capture the result so a stalled W can still pick it up later.
                        r_hold  <= w_valm;
                        r_cnt   <= '0;
                        r_state <= W_stall ? ST_HOLD : ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (!W_stall) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (!W_stall && (W_bubble || w_busy))) begin
            r_w_stat  <= AOK;
            r_w_icode <= NOP;
            r_w_vale  <= '0;
            r_w_valm  <= '0;
            r_w_dste  <= RNONE;
            r_w_dstm  <= RNONE;
        end else if (!W_stall) begin
            r_w_stat  <= m_stat;
            r_w_icode <= M_icode;
            r_w_vale  <= M_valE;
            r_w_valm  <= w_valm;
            r_w_dste  <= M_dstE;
            r_w_dstm  <= M_dstM;
        end
    end

    assign W_stat  = r_w_stat;
    assign W_icode = r_w_icode;
    assign W_valE  = r_w_vale;
    assign W_valM  = r_w_valm;
    assign W_dstE  = r_w_dste;
    assign W_dstM  = r_w_dstm;

endmodule

// File: tb/tb_mem_stage_mc.sv
// Bench for mem_stage_mc: one single-cycle instance and one two-wait-state instance.
// Latency: model follows each instruction through its busy, completion, stall and load cycles.
// Backpressure: the bench acts as the hazard unit, holding M while mem_busy is expected high.
module tb_mem_stage_mc;
    import y86_pkg::*;

    localparam int MW = 32;
    localparam logic [63:0] LIM = 64'(MW * 8);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
    logic [63:0] M_valE, M_valA;
    logic        W_stall, W_bubble;

    logic [3:0]  ms0, ws0, wi0, wde0, wdm0, ms2, ws2, wi2, wde2, wdm2;
    logic [63:0] mv0, wve0, wvm0, mv2, wve2, wvm2;
    logic        busy0, busy2;

    mem_stage_mc #(.MEM_WORDS(MW), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .M_stat(M_stat), .M_icode(sel ? NOP : M_icode),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stall(sel ? 1'b0 : W_stall), .W_bubble(sel ? 1'b0 : W_bubble),
        .m_stat(ms0), .m_valM(mv0), .mem_busy(busy0), .W_stat(ws0), .W_icode(wi0),
        .W_valE(wve0), .W_valM(wvm0), .W_dstE(wde0), .W_dstM(wdm0));

    mem_stage_mc #(.MEM_WORDS(MW), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .M_stat(M_stat), .M_icode(sel ? M_icode : NOP),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stall(sel ? W_stall : 1'b0), .W_bubble(sel ? W_bubble : 1'b0),
        .m_stat(ms2), .m_valM(mv2), .mem_busy(busy2), .W_stat(ws2), .W_icode(wi2),
        .W_valE(wve2), .W_valM(wvm2), .W_dstE(wde2), .W_dstM(wdm2));

    wire [3:0]  a_ms   = sel ? ms2  : ms0;
    wire [63:0] a_mv   = sel ? mv2  : mv0;
    wire        a_busy = sel ? busy2 : busy0;
    wire [3:0]  a_ws   = sel ? ws2  : ws0;
    wire [3:0]  a_wi   = sel ? wi2  : wi0;
    wire [63:0] a_wve  = sel ? wve2 : wve0;
    wire [63:0] a_wvm  = sel ? wvm2 : wvm0;
    wire [3:0]  a_wde  = sel ? wde2 : wde0;
    wire [3:0]  a_wdm  = sel ? wdm2 : wdm0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: memory image per instance and the W register contents.
    logic [63:0] mm [2][MW];
    logic [3:0]  wm_stat, wm_icode, wm_dste, wm_dstm;
    logic [63:0] wm_vale, wm_valm;

    logic        chk_en = 1'b0;
    logic        chk_valm = 1'b0;
    logic [3:0]  exp_mstat;
    logic        exp_busy;
    logic [63:0] exp_valm;

    int busy0_cnt = 0;
    int busy2_cnt = 0;
    int we2_cnt   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (busy0) busy0_cnt++;
        if (busy2) busy2_cnt++;
        if (chk_en) begin
            chk("m_stat",   64'(a_ms),   64'(exp_mstat));
            chk("mem_busy", 64'(a_busy), 64'(exp_busy));
            if (chk_valm) chk("m_valM", a_mv, exp_valm);
            chk("W_stat",  64'(a_ws),  64'(wm_stat));
            chk("W_icode", 64'(a_wi),  64'(wm_icode));
            chk("W_valE",  a_wve,      wm_vale);
            chk("W_valM",  a_wvm,      wm_valm);
            chk("W_dstE",  64'(a_wde), 64'(wm_dste));
            chk("W_dstM",  64'(a_wdm), 64'(wm_dstm));
        end
    end

    always @(posedge clk) begin
        if (dut2.u_dmem.i_we) we2_cnt++;
    end

    task automatic w_bubble_m();
        wm_stat = AOK; wm_icode = NOP; wm_vale = '0; wm_valm = '0; wm_dste = RNONE; wm_dstm = RNONE;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        M_stat = AOK; M_icode = NOP; M_valE = '0; M_valA = '0; M_dstE = RNONE; M_dstM = RNONE;
        W_stall = 1'b0; W_bubble = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        w_bubble_m();
    endtask

    // Presents one instruction and plays the pipeline around it: busy cycles,
    // completion, nstall cycles of W_stall, then a load (or a bubble if bub).
    task automatic issue(input logic [3:0] st, input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm,
                         input int nstall, input bit bub);
        bit rd, wr, mem, ok, en;
        logic [63:0] addr, rv;
        int idx, s, wc;
        s  = sel ? 1 : 0;
        wc = sel ? 2 : 0;
        rd = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        wr = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        mem = rd || wr;
        addr = ((ic == 4'h9) || (ic == 4'hB)) ? va : ve;
        ok = (addr < LIM);
`ifdef MEM_ALIGN_CHECK_EN
        ok = ok && (addr % 8 == 0);
`endif
        idx = ok ? int'(addr / 8) : 0;
        en  = mem && (st == AOK) && ok && (wm_stat == AOK);
        rv  = (en && rd) ? mm[s][idx] : 64'd0;

        M_stat = st; M_icode = ic; M_valE = ve; M_valA = va; M_dstE = de; M_dstM = dm;
        W_stall = 1'b0; W_bubble = 1'b0;
        exp_mstat = (mem && !ok) ? ADR : st;
        chk_en = 1'b1;
        if (en) begin
            for (int i = 0; i < wc; i++) begin
                exp_busy = 1'b1; chk_valm = 1'b0;
                @(posedge clk);
                w_bubble_m();
                #1;
            end
        end
        exp_busy = 1'b0; chk_valm = 1'b1; exp_valm = rv;
        for (int k = 0; k < nstall; k++) begin
            W_stall = 1'b1;
            W_bubble = 1'($urandom_range(0, 1));
            @(posedge clk);
            if (k == 0 && en && wr) mm[s][idx] = va;
            #1;
        end
        W_stall = 1'b0;
        W_bubble = bub;
        @(posedge clk);
        if (nstall == 0 && en && wr) mm[s][idx] = va;
        if (bub) begin
            w_bubble_m();
        end else begin
            wm_stat = exp_mstat; wm_icode = ic; wm_vale = ve; wm_valm = rv; wm_dste = de; wm_dstm = dm;
        end
        #1;
        W_bubble = 1'b0;
    endtask

    function automatic logic [63:0] rnd_addr();
        int r;
        logic [63:0] w;
        r = $urandom_range(0, 9);
        w = 64'($urandom_range(0, MW - 1));
        case (r)
            6:       return (w * 8) + 64'($urandom_range(1, 7));
            7:       return LIM + 64'($urandom_range(0, 15));
            8:       return {$urandom, $urandom};
            9:       return LIM - 64'($urandom_range(1, 8));
            default: return w * 8;
        endcase
    endfunction

    task automatic rnd_run(input int n);
        logic [3:0] st, ic;
        int r, ns;
        for (int t = 0; t < n; t++) begin
            r  = $urandom_range(0, 99);
            st = (r < 85) ? AOK : (r < 90) ? HLT : (r < 95) ? INS : ADR;
            ic = 4'($urandom_range(0, 11));
            ns = ($urandom_range(0, 99) < 20) ? $urandom_range(1, 3) : 0;
            issue(st, ic, rnd_addr(), (ic == 4'h9 || ic == 4'hB) ? rnd_addr() : {$urandom, $urandom},
                  4'($urandom), 4'($urandom), ns, ($urandom_range(0, 99) < 8));
        end
    endtask

    task automatic preload();
        for (int i = 0; i < MW; i++) begin
            issue(AOK, RMMOVQ, 64'(i * 8), {$urandom, $urandom}, RNONE, RNONE, 0, 1'b0);
        end
    endtask

    int b0, w0;

    initial begin
        sel = 1'b0;
        do_reset();
        chk("rst_W_stat",  64'(ws0),  64'h8);
        chk("rst_W_icode", 64'(wi0),  64'h1);
        chk("rst_W_valM",  wvm0,      64'h0);
        chk("rst_W_dstE",  64'(wde0), 64'hF);
        chk("rst_busy",    64'(busy0), 64'h0);

        // Single-cycle instance.
        preload();
        issue(AOK, RMMOVQ, 64'h10, 64'hDEAD, RNONE, RNONE, 0, 1'b0);
        issue(AOK, MRMOVQ, 64'h10, 64'h0, RNONE, 4'h3, 0, 1'b0);
        chk("wc0_load_valM", wvm0, 64'hDEAD);
        issue(AOK, MRMOVQ, LIM, 64'h0, RNONE, 4'h3, 0, 1'b0);
        chk("oob_W_stat", 64'(ws0), 64'h2);
        issue(AOK, RMMOVQ, 64'h10, 64'hBEEF, RNONE, RNONE, 0, 1'b0);
        issue(AOK, MRMOVQ, 64'h10, 64'h0, RNONE, 4'h3, 0, 1'b0);
        chk("suppressed_write", wvm0, 64'hDEAD);
        issue(AOK, MRMOVQ, 64'h13, 64'h0, RNONE, 4'h3, 0, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("misalign_stat", 64'(ws0), 64'h2);
`else
        chk("misalign_word2", wvm0, 64'hDEAD);
`endif
        rnd_run(300);
        chk("wc0_never_busy", 64'(busy0_cnt), 64'h0);

        // Two-wait-state instance.
        sel = 1'b1;
        do_reset();
        preload();
        b0 = busy2_cnt; w0 = we2_cnt;
        issue(AOK, PUSHQ, 64'h80, 64'h1234, 4'h4, RNONE, 0, 1'b0);
        chk("push_busy_cycles", 64'(busy2_cnt - b0), 64'd2);
        chk("push_one_write",   64'(we2_cnt - w0),   64'd1);
        chk("push_W_icode",     64'(wi2),            64'hA);
        w0 = we2_cnt;
        issue(AOK, POPQ, 64'h88, 64'h80, 4'h4, 4'h0, 3, 1'b0);
        chk("pop_hold_valM",  wvm2, 64'h1234);
        chk("pop_no_write",   64'(we2_cnt - w0), 64'd0);

        // Reset while the store is still waiting: the store must be lost.
        w0 = we2_cnt;
        chk_en = 1'b0;
        M_stat = AOK; M_icode = RMMOVQ; M_valE = 64'h80; M_valA = 64'h5555;
        M_dstE = RNONE; M_dstM = RNONE;
        @(posedge clk);
        #1;
        chk("midwait_busy", 64'(busy2), 64'h1);
        rst = 1'b1; M_icode = NOP;
        @(posedge clk);
        #1;
        rst = 1'b0;
        w_bubble_m();
        chk("midwait_rst_icode", 64'(wi2),   64'h1);
        chk("midwait_rst_stat",  64'(ws2),   64'h8);
        chk("midwait_rst_busy",  64'(busy2), 64'h0);
        chk("midwait_no_write",  64'(we2_cnt - w0), 64'd0);
        issue(AOK, MRMOVQ, 64'h80, 64'h0, RNONE, 4'h2, 0, 1'b0);
        chk("midwait_old_value", wvm2, 64'h1234);

        rnd_run(300);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
